// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream sink and instruction-memory write port of the boot loader
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: byte source plus memory observer; slave: the loader itself
    modport master (
        output s_data, s_valid,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  s_data, s_valid,
        output s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that fills instruction memory and gates core reset
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            cpu_rst,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] words_loaded
);
    localparam int          IW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              in_frame;
    logic              xfer;

    assign in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer     = bus.s_valid && in_frame;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        bidx_d   = bidx_q;
        asm_d    = asm_q;
        csum_d   = csum_q;
        idle_d   = idle_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN0;
                    cnt_d   = '0;
                    csum_d  = '0;
                    idle_d  = '0;
                    bidx_d  = '0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_lo_d = bus.s_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d = {bus.s_data, len_lo_q};
                    if ({1'b0, len_d} > MAX_N) begin
                        state_d = S_ERR;
                    end else if (len_d == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    bidx_d = bidx_q + 2'd1;
                    // the fourth byte goes straight into the write register, bypassing asm
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = {bus.s_data, asm_q};
                        cnt_d   = cnt_q + 1'b1;
                        if ((16'(cnt_q) + 16'd1) == len_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        asm_d[{bidx_q, 3'b000} +: 8] = bus.s_data;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (bus.s_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (in_frame) begin
            if (xfer) begin
                idle_d = '0;
                csum_d = csum_q ^ bus.s_data;
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
                state_d = S_ERR;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            bidx_q   <= '0;
            asm_q    <= '0;
            csum_q   <= '0;
            idle_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            bidx_q   <= bidx_d;
            asm_q    <= asm_d;
            csum_q   <= csum_d;
            idle_q   <= idle_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.s_ready    = in_frame;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = in_frame;
    assign cpu_rst        = (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERR);
    assign words_loaded   = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cpu_rst, busy, done, error;
    logic [AW:0]   words_loaded;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [39:0] wr_q[$];
    logic [39:0] exp_q[$];
    int          m_nsend;
    bit          m_ok;
    int          m_wl;

    always @(negedge clk) begin
        if (bus.imem_we) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
    end

    typedef struct packed {
        logic [95:0] fr;
        int          nb;
        int          gap;
        int          start_at;
        int          exp_nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_done;
        logic        exp_err;
        int          exp_wl;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        bus.s_valid = 1'b0;
        repeat (gap) step();
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && t < 40) begin
            step();
            t++;
        end
        chk("send_byte_s_ready", bus.s_ready, 1);
        if (bus.s_ready) step();
        bus.s_valid = 1'b0;
    endtask

    // gap_mode < 0 picks a random 0..3 cycle gap before each byte
    task automatic drive_frame(input logic [7:0] fb[$], input int nsend, input int gap_mode,
                               input int start_at);
        wr_q.delete();
        pulse_start();
        for (int i = 0; i < nsend; i++) begin
            if (i == start_at) pulse_start();
            send_byte(fb[i], (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode);
        end
        chk("busy_after_last_byte", busy, 0);
        repeat (3) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_imem_we"}, bus.imem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_imem_addr"}, bus.imem_addr, 0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        chk({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic apply_vec(input int k);
        logic [7:0] fb[$];
        vec_t       v;
        v = vt[k];
        for (int i = 0; i < v.nb; i++) fb.push_back(v.fr[8*(v.nb-1-i) +: 8]);
        drive_frame(fb, v.nb, v.gap, v.start_at);
        chk($sformatf("vec%0d_nwrites", k), wr_q.size(), v.exp_nw);
        if (v.exp_nw > 0) chk($sformatf("vec%0d_write0", k), wr_q[0], {8'd0, v.w0});
        if (v.exp_nw > 1) chk($sformatf("vec%0d_write1", k), wr_q[1], {8'd1, v.w1});
        chk($sformatf("vec%0d_done", k), done, v.exp_done);
        chk($sformatf("vec%0d_error", k), error, v.exp_err);
        chk($sformatf("vec%0d_cpu_rst", k), cpu_rst, !v.exp_done);
        chk($sformatf("vec%0d_words_loaded", k), words_loaded, v.exp_wl);
        chk($sformatf("vec%0d_s_ready", k), bus.s_ready, 0);
    endtask

    // frame semantics straight from the frame format: length, LE words, XOR checksum
    task automatic ref_model(input logic [7:0] fb[$]);
        int         n;
        logic [7:0] x;
        exp_q.delete();
        n = int'(fb[0]) + 256 * int'(fb[1]);
        if (n > (1 << AW)) begin
            m_nsend = 2;
            m_ok    = 1'b0;
            m_wl    = 0;
        end else begin
            for (int w = 0; w < n; w++)
                exp_q.push_back({AW'(w), fb[2+4*w+3], fb[2+4*w+2], fb[2+4*w+1], fb[2+4*w]});
            x = 8'h00;
            for (int i = 0; i < 4 * n + 2; i++) x = x ^ fb[i];
            m_ok    = (fb[4*n+2] == x);
            m_nsend = 4 * n + 3;
            m_wl    = n;
        end
    endtask

    task automatic run_random(input int r);
        logic [7:0] fb[$];
        int         n;
        logic [7:0] x;
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 2000)) : int'($urandom_range(0, 6));
        fb.push_back(n[7:0]);
        fb.push_back(n[15:8]);
        if (n <= 256) begin
            for (int j = 0; j < 4 * n; j++) fb.push_back(8'($urandom_range(0, 255)));
            x = 8'h00;
            foreach (fb[i]) x = x ^ fb[i];
            if ($urandom_range(0, 4) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
            fb.push_back(x);
        end
        ref_model(fb);
        drive_frame(fb, m_nsend, -1, -1);
        chk($sformatf("rnd%0d_nwrites", r), wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("rnd%0d_write%0d", r, i), wr_q[i], exp_q[i]);
        chk($sformatf("rnd%0d_done", r), done, m_ok);
        chk($sformatf("rnd%0d_error", r), error, !m_ok);
        chk($sformatf("rnd%0d_cpu_rst", r), cpu_rst, !m_ok);
        chk($sformatf("rnd%0d_words_loaded", r), words_loaded, m_wl);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded bound 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{96'h02_00_13_00_50_00_B3_00_21_00_D3, 11, 0, -1, 2, 32'h00500013, 32'h002100B3, 1'b1, 1'b0, 2};
        vt[1] = '{96'h02_00_13_00_50_00_B3_00_21_00_D2, 11, 0, -1, 2, 32'h00500013, 32'h002100B3, 1'b0, 1'b1, 2};
        vt[2] = '{96'h01_01, 2, 0, -1, 0, 32'h0, 32'h0, 1'b0, 1'b1, 0};
        vt[3] = '{96'h00_00_00, 3, 0, -1, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0};
        vt[4] = '{96'h02_00_13_00_50_00_B3_00_21_00_D3, 11, 3, -1, 2, 32'h00500013, 32'h002100B3, 1'b1, 1'b0, 2};
        vt[5] = '{96'h02_00_13_00_50_00_B3_00_21_00_D3, 11, 0, 6, 2, 32'h00500013, 32'h002100B3, 1'b1, 1'b0, 2};

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 6; k++) apply_vec(k);

        // idle timeout: 15 idle cycles tolerated, the 16th aborts
        wr_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        repeat (TO - 1) step();
        chk("timeout_busy_before", busy, 1);
        chk("timeout_error_before", error, 0);
        step();
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_cpu_rst", cpu_rst, 1);
        chk("timeout_s_ready", bus.s_ready, 0);

        // asynchronous reset after five payload bytes
        wr_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_byte(8'hB3, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (3) step();
        chk("midreset_nwrites", wr_q.size(), 1);
        chk("midreset_write0", wr_q[0], {8'd0, 32'h00500013});
        rst_n = 1'b1;
        step();
        apply_vec(0);

        for (int r = 0; r < 24; r++) run_random(r);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
